// File: rtl/ahb_package.sv
// rtl/ahb_package.sv - htrans encodings and one-hot helpers shared by the AHB slave-side mux
package ahb_package;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  // Helpers operate on a zero-extended vector so one definition serves every channel count
  localparam int MAX_CH = 32;

  function automatic logic is_onehot(input logic [MAX_CH-1:0] v);
    return (v != '0) && ((v & (v - MAX_CH'(1))) == '0);
  endfunction

  function automatic int onehot_to_idx(input logic [MAX_CH-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_onehot_dec.sv
// rtl/ahb_onehot_dec.sv - one-hot/zero classification and index of a grant vector
module ahb_onehot_dec
  import ahb_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int IDX_W       = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
  input  logic [CHANNEL_NUM-1:0] vec_i,
  output logic                   onehot_o,
  output logic                   zero_o,
  output logic [IDX_W-1:0]       idx_o
);

  logic [MAX_CH-1:0] vec_ext;

  always_comb begin
    vec_ext                  = '0;
    vec_ext[CHANNEL_NUM-1:0] = vec_i;
  end

  assign onehot_o = is_onehot(vec_ext);
  assign zero_o   = (vec_i == '0);
  assign idx_o    = IDX_W'(onehot_to_idx(vec_ext));

endmodule

// File: rtl/ahb_mi_mux_pipe.sv
// rtl/ahb_mi_mux_pipe.sv - per-slave AHB multi-master mux routing address and data phases
// Address payload follows the live grant; write data follows a grant registered on hready.
module ahb_mi_mux_pipe
  import ahb_package::*;
#(
  parameter int CHANNEL_NUM = 2,
  parameter int ADDR_W      = 46,
  parameter int DATA_W      = 32,
  parameter int HTRANS_LSB  = 32,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                   hclk,
  input  logic                   hreset_n,
  input  logic [ADDR_W-1:0]      addr_in [CHANNEL_NUM],
  input  logic [DATA_W-1:0]      wdata_in [CHANNEL_NUM],
  input  logic [CHANNEL_NUM-1:0] sel,
  input  logic                   hready,
  input  logic                   err_clr,
  output logic [ADDR_W-1:0]      addr_out,
  output logic [DATA_W-1:0]      wdata_out,
  output logic [CHANNEL_NUM-1:0] data_sel,
  output logic                   data_valid,
  output logic                   sel_err,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  localparam int IDX_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  logic             sel_onehot, sel_zero;
  logic [IDX_W-1:0] sel_idx;
  logic             dsel_onehot, dsel_zero;
  logic [IDX_W-1:0] dsel_idx;
  logic [1:0]       htrans;
  logic             xfer_active;

  logic [CHANNEL_NUM-1:0] data_sel_q, data_sel_d;
  logic [ERR_CNT_W-1:0]   err_cnt_q, err_cnt_d;

  ahb_onehot_dec #(.CHANNEL_NUM(CHANNEL_NUM), .IDX_W(IDX_W)) u_sel_dec (
    .vec_i    (sel),
    .onehot_o (sel_onehot),
    .zero_o   (sel_zero),
    .idx_o    (sel_idx)
  );

  ahb_onehot_dec #(.CHANNEL_NUM(CHANNEL_NUM), .IDX_W(IDX_W)) u_dsel_dec (
    .vec_i    (data_sel_q),
    .onehot_o (dsel_onehot),
    .zero_o   (dsel_zero),
    .idx_o    (dsel_idx)
  );

  // An invalid grant drives an all-zero payload, which the slave sees as htrans IDLE
  assign addr_out    = sel_onehot ? addr_in[sel_idx] : '0;
  assign sel_err     = !sel_zero && !sel_onehot;
  assign htrans      = addr_out[HTRANS_LSB +: 2];
  assign xfer_active = (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);

  always_comb begin
    data_sel_d = data_sel_q;
    if (hready) begin
      data_sel_d = (sel_onehot && xfer_active) ? sel : '0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (sel_err && hready && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      data_sel_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      data_sel_q <= data_sel_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign data_sel   = data_sel_q;
  assign data_valid = !dsel_zero;
  assign wdata_out  = dsel_onehot ? wdata_in[dsel_idx] : '0;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ahb_mi_mux_pipe.sv
// tb/tb_ahb_mi_mux_pipe.sv - scoreboard bench for the per-slave AHB multi-master mux
module tb_ahb_mi_mux_pipe;

  localparam int CH = 4;
  localparam int AW = 46;
  localparam int DW = 32;
  localparam int HL = 32;
  localparam int EW = 2;

  logic          hclk = 1'b0;
  logic          hreset_n;
  logic [AW-1:0] addr_in [CH];
  logic [DW-1:0] wdata_in [CH];
  logic [CH-1:0] sel;
  logic          hready;
  logic          err_clr;
  logic [AW-1:0] addr_out;
  logic [DW-1:0] wdata_out;
  logic [CH-1:0] data_sel;
  logic          data_valid;
  logic          sel_err;
  logic [EW-1:0] err_cnt;

  typedef struct packed {
    logic [CH-1:0] dsel;
    logic [DW-1:0] wdata;
    logic [EW-1:0] err;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  logic [CH-1:0] m_dsel;
  logic [EW-1:0] m_err;
  int            checks = 0;
  int            errors = 0;

  ahb_mi_mux_pipe #(
    .CHANNEL_NUM(CH), .ADDR_W(AW), .DATA_W(DW), .HTRANS_LSB(HL), .ERR_CNT_W(EW)
  ) dut (
    .hclk(hclk), .hreset_n(hreset_n), .addr_in(addr_in), .wdata_in(wdata_in),
    .sel(sel), .hready(hready), .err_clr(err_clr), .addr_out(addr_out),
    .wdata_out(wdata_out), .data_sel(data_sel), .data_valid(data_valid),
    .sel_err(sel_err), .err_cnt(err_cnt)
  );

  always #5 hclk = ~hclk;

  function automatic logic [AW-1:0] mk_addr(input logic [1:0] tr, input logic [31:0] a);
    return {12'hA5C, tr, a};
  endfunction

  function automatic logic [AW-1:0] m_addr(input logic [CH-1:0] s);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) if (s == (CH'(1) << i)) r = addr_in[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] m_wdata(input logic [CH-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) if (d == (CH'(1) << i)) r = wdata_in[i];
    return r;
  endfunction

  task automatic cycle();
    exp_t          x;
    logic [AW-1:0] a;
    a = m_addr(sel);
    if (hready) m_dsel = ($countones(sel) == 1 && a[HL+1]) ? sel : '0;
    if (err_clr) m_err = '0;
    else if (hready && $countones(sel) > 1 && m_err != '1) m_err = m_err + 1'b1;
    x.dsel  = m_dsel;
    x.wdata = m_wdata(m_dsel);
    x.err   = m_err;
    sb.push_back(x);
    @(posedge hclk);
    #1;
  endtask

  task automatic test_reset();
    hreset_n = 1'b0;
    sel      = 4'b0100;
    repeat (2) @(posedge hclk);
    #1;
    checks += 5;
    if (data_sel !== '0) begin errors++; $display("FAIL reset_data_sel got %h want 0", data_sel); end
    if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_data_valid got %b want 0", data_valid); end
    if (err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    if (wdata_out !== '0) begin errors++; $display("FAIL reset_wdata got %h want 0", wdata_out); end
    if (addr_out !== m_addr(4'b0100)) begin errors++; $display("FAIL reset_addr_out got %h want %h", addr_out, m_addr(4'b0100)); end
    sel      = '0;
    hreset_n = 1'b1;
    m_dsel   = '0;
    m_err    = '0;
  endtask

  task automatic test_pipelined_write();
    sel    = 4'b0010;
    hready = 1'b1;
    cycle();
    e = sb.pop_front();
    checks += 3;
    if (data_sel !== e.dsel) begin errors++; $display("FAIL pipe_data_sel got %h want %h", data_sel, e.dsel); end
    if (wdata_out !== e.wdata) begin errors++; $display("FAIL pipe_wdata got %h want %h", wdata_out, e.wdata); end
    if (data_valid !== 1'b1) begin errors++; $display("FAIL pipe_data_valid got %b want 1", data_valid); end
  endtask

  task automatic test_wait_states();
    hready = 1'b0;
    sel    = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      cycle();
      e = sb.pop_front();
      checks += 2;
      if (data_sel !== e.dsel) begin errors++; $display("FAIL wait%0d_data_sel got %h want %h", i, data_sel, e.dsel); end
      if (wdata_out !== e.wdata) begin errors++; $display("FAIL wait%0d_wdata got %h want %h", i, wdata_out, e.wdata); end
    end
    hready = 1'b1;
    cycle();
    e = sb.pop_front();
    checks += 2;
    if (data_sel !== e.dsel) begin errors++; $display("FAIL wait_release_data_sel got %h want %h", data_sel, e.dsel); end
    if (wdata_out !== e.wdata) begin errors++; $display("FAIL wait_release_wdata got %h want %h", wdata_out, e.wdata); end
  endtask

  task automatic test_idle();
    addr_in[0] = mk_addr(2'b00, 32'h0000_0040);
    sel        = 4'b0001;
    #1;
    checks++;
    if (addr_out !== m_addr(sel)) begin errors++; $display("FAIL idle_addr_out got %h want %h", addr_out, m_addr(sel)); end
    cycle();
    e = sb.pop_front();
    checks += 2;
    if (data_sel !== e.dsel) begin errors++; $display("FAIL idle_data_sel got %h want %h", data_sel, e.dsel); end
    if (data_valid !== (|e.dsel)) begin errors++; $display("FAIL idle_data_valid got %b want %b", data_valid, |e.dsel); end
    addr_in[0] = mk_addr(2'b10, 32'h0000_0000);
  endtask

  task automatic test_select_fault();
    sel = 4'b0110;
    #1;
    checks += 2;
    if (addr_out !== '0) begin errors++; $display("FAIL fault_addr_out got %h want 0", addr_out); end
    if (sel_err !== 1'b1) begin errors++; $display("FAIL fault_sel_err got %b want 1", sel_err); end
    for (int i = 0; i < 5; i++) begin
      cycle();
      e = sb.pop_front();
      checks += 2;
      if (err_cnt !== e.err) begin errors++; $display("FAIL fault%0d_err_cnt got %0d want %0d", i, err_cnt, e.err); end
      if (data_sel !== e.dsel) begin errors++; $display("FAIL fault%0d_data_sel got %h want %h", i, data_sel, e.dsel); end
    end
    checks++;
    if (err_cnt !== 2'd3) begin errors++; $display("FAIL fault_saturate got %0d want 3", err_cnt); end
    err_clr = 1'b1;
    sel     = 4'b1010;
    cycle();
    e = sb.pop_front();
    checks++;
    if (err_cnt !== e.err) begin errors++; $display("FAIL fault_clear got %0d want %0d", err_cnt, e.err); end
    err_clr = 1'b0;
    sel     = '0;
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] seq [6];
    seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
    seq[3] = 4'b1000; seq[4] = 4'b0100; seq[5] = 4'b0001;
    addr_in[3] = mk_addr(2'b11, 32'h0000_0300);
    addr_in[2] = mk_addr(2'b01, 32'h0000_0200);
    hready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) addr_in[2] = mk_addr(2'b10, 32'h0000_0204);
      sel = seq[i];
      cycle();
      e = sb.pop_front();
      checks += 2;
      if (data_sel !== e.dsel) begin errors++; $display("FAIL b2b%0d_data_sel got %h want %h", i, data_sel, e.dsel); end
      if (wdata_out !== e.wdata) begin errors++; $display("FAIL b2b%0d_wdata got %h want %h", i, wdata_out, e.wdata); end
    end
  endtask

  task automatic test_async_reset();
    sel = 4'b0100;
    cycle();
    e = sb.pop_front();
    checks++;
    if (data_sel !== e.dsel) begin errors++; $display("FAIL arst_load got %h want %h", data_sel, e.dsel); end
    #2 hreset_n = 1'b0;
    #1;
    m_dsel = '0;
    m_err  = '0;
    checks += 2;
    if (data_sel !== '0) begin errors++; $display("FAIL arst_data_sel got %h want 0", data_sel); end
    if (wdata_out !== '0) begin errors++; $display("FAIL arst_wdata got %h want 0", wdata_out); end
    #2 hreset_n = 1'b1;
    sel = 4'b0010;
    cycle();
    e = sb.pop_front();
    checks += 2;
    if (data_sel !== e.dsel) begin errors++; $display("FAIL arst_reload got %h want %h", data_sel, e.dsel); end
    if (wdata_out !== e.wdata) begin errors++; $display("FAIL arst_reload_wdata got %h want %h", wdata_out, e.wdata); end
  endtask

  initial begin
    for (int i = 0; i < CH; i++) begin
      addr_in[i]  = mk_addr(2'b10, 32'(i) << 8);
      wdata_in[i] = 32'h1111_0000 + 32'(i);
    end
    wdata_in[1] = 32'hDEAD_BEEF;
    hready  = 1'b1;
    err_clr = 1'b0;
    m_dsel  = '0;
    m_err   = '0;
    test_reset();
    test_pipelined_write();
    test_wait_states();
    test_idle();
    test_select_fault();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
